// File: rtl/isp_stream_top_if.sv
// Beat-level stream bundle shared by the Bayer input and the processed output.
// Ports: pixel (sample), valid (beat strobe), color (VOID/RED/GREEN/BLUE tag),
//        last_col (end of row), last_pic (end of frame). No ready: the sink always accepts.
interface isp_stream_top_if #(
  parameter int COLOR_DEPTH = 8
);
  logic [COLOR_DEPTH-1:0] pixel;
  logic                   valid;
  logic [1:0]             color;
  logic                   last_col;
  logic                   last_pic;

  modport master (output pixel, valid, color, last_col, last_pic);
  modport slave  (input  pixel, valid, color, last_col, last_pic);
endinterface

// File: rtl/isp_stream_top.sv
// Purpose: ISP front end; per frame bypasses RGGB Bayer beats, demosaics 2x2 quads to R,G,B beats,
//          or emits the frame mean of the demosaiced RGB. Optional macro ISP_GAIN_EN adds Q4.4 gains.
// Latency: bypass 1 cycle; R,G,B beats start 1 cycle after the B pixel (2 with ISP_GAIN_EN).
// Backpressure: none in either direction; a 3-beat backlog absorbs short overlaps between emissions.
// Ports: clk, rst_n (synchronous, active-high), src (Bayer input stream), dst (output stream),
//        mode_in (0 bypass, 1 demosaic, 2 mean, 3 bypass), finish_operation (frame fully emitted).
module isp_stream_top #(
  parameter int COLOR_DEPTH = 8,
  parameter int IMG_COL     = 8,
`ifdef ISP_GAIN_EN
  parameter logic [15:0] GAIN_R = 16'd16,
  parameter logic [15:0] GAIN_G = 16'd16,
  parameter logic [15:0] GAIN_B = 16'd16,
`endif
  parameter int LOG2_NPIX   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  isp_stream_top_if.slave  src,
  isp_stream_top_if.master dst,
  input  logic [1:0]       mode_in,
  output logic             finish_operation
);

  localparam int CW = (IMG_COL > 2) ? $clog2(IMG_COL) : 1;
  localparam int NQ = IMG_COL / 2;
  localparam int LW = (NQ > 1) ? $clog2(NQ) : 1;
  localparam int SW = COLOR_DEPTH + LOG2_NPIX;
  localparam int QD = 3;

  localparam logic [1:0] C_VOID = 2'd0;
  localparam logic [1:0] C_RED  = 2'd1;
  localparam logic [1:0] C_GRN  = 2'd2;
  localparam logic [1:0] C_BLU  = 2'd3;

  localparam logic [1:0] M_DEMOSAIC = 2'd1;
  localparam logic [1:0] M_MEAN     = 2'd2;

  typedef struct packed {
    logic [1:0]             color;
    logic [COLOR_DEPTH-1:0] pix;
    logic                   lc;
    logic                   lp;
  } beat_t;

  // Frame / position tracking
  logic [1:0]             mode_q;
  logic                   in_frame;
  logic                   odd_row;
  logic [CW-1:0]          col;
  logic [COLOR_DEPTH-1:0] lb_r [0:NQ-1];
  logic [COLOR_DEPTH-1:0] lb_g [0:NQ-1];
  logic [COLOR_DEPTH-1:0] g2;
  logic [SW-1:0]          sum_r, sum_g, sum_b;

  // Per-beat combinational decode
  logic [1:0]             cur_mode;
  logic                   quad_mode, quad_done, early_end;
  logic [LW-1:0]          lb_idx;
  logic [COLOR_DEPTH:0]   g_wide;
  logic [COLOR_DEPTH-1:0] q_r, q_g, q_b;
  logic [SW-1:0]          nsum_r, nsum_g, nsum_b;
  logic                   tri_vld, tri_lc, tri_lp;
  logic [COLOR_DEPTH-1:0] tri_r, tri_g, tri_b;
  logic                   one_vld;
  beat_t                  one_beat;

  // Triple presented to the output backlog (after optional gain stage)
  logic                   push_tri, p_lc, p_lp;
  logic [COLOR_DEPTH-1:0] p_r, p_g, p_b;

  // Output backlog and output register
  beat_t                  q [0:QD-1];
  logic [1:0]             q_cnt;
  beat_t                  cat [0:7];
  logic [2:0]             n;
  beat_t                  out_b;
  logic                   out_vld;

  always_comb begin
    // Mode is taken live on the first beat of a frame, then held from mode_q.
    cur_mode  = in_frame ? mode_q : mode_in;
    quad_mode = (cur_mode == M_DEMOSAIC) || (cur_mode == M_MEAN);
    lb_idx    = LW'(col >> 1);
    g_wide    = {1'b0, lb_g[lb_idx]} + {1'b0, g2};
    q_r       = lb_r[lb_idx];
    q_g       = COLOR_DEPTH'(g_wide >> 1);
    q_b       = src.pixel;
    quad_done = src.valid && quad_mode && odd_row && col[0];
    // A frame ending anywhere but on a B pixel has no quad to report.
    early_end = src.valid && quad_mode && src.last_pic && !(odd_row && col[0]);
    nsum_r    = sum_r + SW'(q_r);
    nsum_g    = sum_g + SW'(q_g);
    nsum_b    = sum_b + SW'(q_b);

    tri_vld = quad_done && ((cur_mode == M_DEMOSAIC) || src.last_pic);
    if (cur_mode == M_MEAN) begin
      tri_r  = COLOR_DEPTH'(nsum_r >> LOG2_NPIX);
      tri_g  = COLOR_DEPTH'(nsum_g >> LOG2_NPIX);
      tri_b  = COLOR_DEPTH'(nsum_b >> LOG2_NPIX);
      tri_lc = 1'b1;
      tri_lp = 1'b1;
    end else begin
      tri_r  = q_r;
      tri_g  = q_g;
      tri_b  = q_b;
      tri_lc = src.last_col;
      tri_lp = src.last_pic;
    end

    one_vld = (src.valid && !quad_mode) || early_end;
    if (quad_mode) one_beat = '{C_VOID, '0, 1'b0, 1'b1};
    else           one_beat = '{src.color, src.pixel, src.last_col, src.last_pic};
  end

`ifdef ISP_GAIN_EN
  function automatic logic [COLOR_DEPTH-1:0] sat_gain(input logic [COLOR_DEPTH-1:0] c,
                                                      input logic [15:0] g);
    logic [COLOR_DEPTH+15:0] prod;
    prod = ({16'd0, c} * {{COLOR_DEPTH{1'b0}}, g}) >> 4;
    return (|prod[COLOR_DEPTH+15:COLOR_DEPTH]) ? {COLOR_DEPTH{1'b1}} : prod[COLOR_DEPTH-1:0];
  endfunction

  logic                   st_vld, st_lc, st_lp;
  logic [COLOR_DEPTH-1:0] st_r, st_g, st_b;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      st_vld <= 1'b0;
      st_lc  <= 1'b0;
      st_lp  <= 1'b0;
      st_r   <= '0;
      st_g   <= '0;
      st_b   <= '0;
    end else begin
      st_vld <= tri_vld;
      st_lc  <= tri_lc;
      st_lp  <= tri_lp;
      st_r   <= tri_r;
      st_g   <= tri_g;
      st_b   <= tri_b;
    end
  end

  always_comb begin
    push_tri = st_vld;
    p_r      = sat_gain(st_r, GAIN_R);
    p_g      = sat_gain(st_g, GAIN_G);
    p_b      = sat_gain(st_b, GAIN_B);
    p_lc     = st_lc;
    p_lp     = st_lp;
  end
`else
  always_comb begin
    push_tri = tri_vld;
    p_r      = tri_r;
    p_g      = tri_g;
    p_b      = tri_b;
    p_lc     = tri_lc;
    p_lp     = tri_lp;
  end
`endif

  // Backlog ++ new beats; head goes to the output register, the rest is kept.
  // The triple is appended before the single beat because it belongs to an older input.
  always_comb begin
    for (int i = 0; i < 8; i++) cat[i] = '0;
    for (int i = 0; i < QD; i++) cat[i] = q[i];
    n = {1'b0, q_cnt};
    if (push_tri) begin
      cat[n]        = '{C_RED, p_r, 1'b0, 1'b0};
      cat[n + 3'd1] = '{C_GRN, p_g, 1'b0, 1'b0};
      cat[n + 3'd2] = '{C_BLU, p_b, p_lc, p_lp};
      n             = n + 3'd3;
    end
    if (one_vld) begin
      cat[n] = one_beat;
      n      = n + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      out_vld <= 1'b0;
      out_b   <= '0;
      q_cnt   <= '0;
      for (int i = 0; i < QD; i++) q[i] <= '0;
    end else begin
      out_vld <= (n != 3'd0);
      out_b   <= (n != 3'd0) ? cat[0] : '0;
      for (int i = 0; i < QD; i++) q[i] <= cat[i+1];
      if (n == 3'd0)     q_cnt <= '0;
      else if (n > 3'd4) q_cnt <= 2'd3;
      else               q_cnt <= 2'(n - 3'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      mode_q   <= '0;
      in_frame <= 1'b0;
      odd_row  <= 1'b0;
      col      <= '0;
      g2       <= '0;
      sum_r    <= '0;
      sum_g    <= '0;
      sum_b    <= '0;
      for (int i = 0; i < NQ; i++) begin
        lb_r[i] <= '0;
        lb_g[i] <= '0;
      end
    end else if (src.valid) begin
      mode_q   <= cur_mode;
      in_frame <= !src.last_pic;
      if (src.last_pic) begin
        odd_row <= 1'b0;
        col     <= '0;
      end else if (src.last_col) begin
        odd_row <= !odd_row;
        col     <= '0;
      end else begin
        col <= col + CW'(1);
      end

      if (!odd_row) begin
        if (!col[0]) lb_r[lb_idx] <= src.pixel;
        else         lb_g[lb_idx] <= src.pixel;
      end else if (!col[0]) begin
        g2 <= src.pixel;
      end

      if (early_end || (quad_done && src.last_pic)) begin
        sum_r <= '0;
        sum_g <= '0;
        sum_b <= '0;
      end else if (quad_done && (cur_mode == M_MEAN)) begin
        sum_r <= nsum_r;
        sum_g <= nsum_g;
        sum_b <= nsum_b;
      end
    end
  end

  // Raised by the final beat of a frame; cleared when the next frame starts arriving.
  always_ff @(posedge clk) begin
    if (rst_n)                        finish_operation <= 1'b0;
    else if (out_vld && out_b.lp)     finish_operation <= 1'b1;
    else if (src.valid)               finish_operation <= 1'b0;
  end

  assign dst.valid    = out_vld;
  assign dst.pixel    = out_b.pix;
  assign dst.color    = out_b.color;
  assign dst.last_col = out_b.lc;
  assign dst.last_pic = out_b.lp;

endmodule

// File: tb/tb_isp_stream_top.sv
module tb_isp_stream_top;
  localparam int CD = 8;
  localparam int IC = 4;
  localparam int L2 = 1;

  typedef struct packed {
    logic [1:0]    color;
    logic [CD-1:0] pix;
    logic          lc;
    logic          lp;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] mode_in;
  logic       finish_operation;

  always #5 clk = ~clk;

  isp_stream_top_if #(.COLOR_DEPTH(CD)) src_if ();
  isp_stream_top_if #(.COLOR_DEPTH(CD)) dst_if ();

  isp_stream_top #(
    .COLOR_DEPTH(CD),
    .IMG_COL(IC),
`ifdef ISP_GAIN_EN
    .GAIN_R(16'd32),
    .GAIN_G(16'd16),
    .GAIN_B(16'd24),
`endif
    .LOG2_NPIX(L2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .src(src_if),
    .dst(dst_if),
    .mode_in(mode_in),
    .finish_operation(finish_operation)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];

  logic [CD-1:0] img [0:3][0:3];
  logic [1:0]    clr [0:3][0:3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Channel gain as seen downstream: min((c*g)>>4, 255) when gains are built in.
  function automatic int gf(input int v, input int g);
`ifdef ISP_GAIN_EN
    int t;
    t = (v * g) >> 4;
    return (t > 255) ? 255 : t;
`else
    return v + 0 * g;
`endif
  endfunction

  function automatic exp_t mk(input int c, input int p, input bit lc, input bit lp);
    exp_t e;
    e.color = 2'(c);
    e.pix   = CD'(p);
    e.lc    = lc;
    e.lp    = lp;
    return e;
  endfunction

  function automatic void push_rgb(input int r, input int g, input int b, input bit lc, input bit lp);
    exp_q.push_back(mk(1, gf(r, 32), 1'b0, 1'b0));
    exp_q.push_back(mk(2, gf(g, 16), 1'b0, 1'b0));
    exp_q.push_back(mk(3, gf(b, 24), lc, lp));
  endfunction

  // Monitor: every output beat must match the oldest outstanding expectation.
  initial begin
    exp_t got, e;
    forever begin
      @(negedge clk);
      if (dst_if.valid === 1'b1) begin
        got = {dst_if.color, dst_if.pixel, dst_if.last_col, dst_if.last_pic};
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got %h expected none", got);
        end else begin
          e = exp_q.pop_front();
          check("out_beat", 32'(got), 32'(e));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic idle_src();
    src_if.valid    = 1'b0;
    src_if.pixel    = '0;
    src_if.color    = '0;
    src_if.last_col = 1'b0;
    src_if.last_pic = 1'b0;
  endtask

  task automatic send(input logic [CD-1:0] p, input logic [1:0] c, input bit lc, input bit lp, input int gap);
    src_if.pixel    = p;
    src_if.color    = c;
    src_if.last_col = lc;
    src_if.last_pic = lp;
    src_if.valid    = 1'b1;
    @(posedge clk); #1;
    idle_src();
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  // Drives img/clr row by row; mode_in is only meaningful on the first beat, later beats scramble it.
  task automatic drive_frame(input logic [1:0] mode, input int rows);
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < IC; c++) begin
        mode_in = (r == 0 && c == 0) ? mode : 2'($urandom_range(0, 3));
        send(img[r][c], clr[r][c], c == IC - 1, (r == rows - 1) && (c == IC - 1),
             $urandom_range(1, 3));
        if (r == 0 && c == 0) check("finish_cleared", 32'(finish_operation), 32'd0);
      end
    end
  endtask

  task automatic drain_and_finish(input string name);
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 60) begin
      @(negedge clk);
      budget++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_drain: got %0d beats outstanding expected 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
    check({name, "_finish"}, 32'(finish_operation), 32'd1);
  endtask

  // Reference: frame-level arithmetic over the stored image.
  task automatic model_frame(input logic [1:0] mode, input int rows);
    int sr, sg, sb, r, g, b;
    bit lastq;
    sr = 0; sg = 0; sb = 0;
    if (mode == 2'd1 || mode == 2'd2) begin
      for (int i = 0; i < rows / 2; i++) begin
        for (int j = 0; j < IC / 2; j++) begin
          r = int'(img[2*i][2*j]);
          g = (int'(img[2*i][2*j+1]) + int'(img[2*i+1][2*j])) / 2;
          b = int'(img[2*i+1][2*j+1]);
          lastq = (i == rows / 2 - 1) && (j == IC / 2 - 1);
          if (mode == 2'd1) push_rgb(r, g, b, j == IC / 2 - 1, lastq);
          sr += r; sg += g; sb += b;
        end
      end
      if (mode == 2'd2) push_rgb(sr >> L2, sg >> L2, sb >> L2, 1'b1, 1'b1);
    end else begin
      for (int rr = 0; rr < rows; rr++)
        for (int c = 0; c < IC; c++)
          exp_q.push_back(mk(int'(clr[rr][c]), int'(img[rr][c]), c == IC - 1,
                             (rr == rows - 1) && (c == IC - 1)));
    end
  endtask

  task automatic load_spec_frame(input int r0);
    img[0][0] = CD'(r0); img[0][1] = 8'd20; img[0][2] = 8'd30; img[0][3] = 8'd40;
    img[1][0] = 8'd22;   img[1][1] = 8'd50; img[1][2] = 8'd41; img[1][3] = 8'd60;
    for (int r = 0; r < 4; r++) for (int c = 0; c < IC; c++) clr[r][c] = 2'd0;
  endtask

  initial begin
    idle_src();
    mode_in = 2'd0;
    rst_n   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_valid",    32'(dst_if.valid),    32'd0);
    check("rst_pixel",    32'(dst_if.pixel),    32'd0);
    check("rst_color",    32'(dst_if.color),    32'd0);
    check("rst_last_col", 32'(dst_if.last_col), 32'd0);
    check("rst_last_pic", 32'(dst_if.last_pic), 32'd0);
    check("rst_finish",   32'(finish_operation), 32'd0);
    @(posedge clk); #1;

    // Bypass: one-cycle registered echo of pixel/tag/flags.
    mode_in = 2'd0;
    exp_q.push_back(mk(2, 8'h5A, 1'b1, 1'b0));
    src_if.pixel = 8'h5A; src_if.color = 2'd2; src_if.last_col = 1'b1; src_if.valid = 1'b1;
    @(posedge clk); #1;
    idle_src();
    check("byp_valid",    32'(dst_if.valid),    32'd1);
    check("byp_pixel",    32'(dst_if.pixel),    32'h5A);
    check("byp_color",    32'(dst_if.color),    32'd2);
    check("byp_last_col", 32'(dst_if.last_col), 32'd1);
    @(posedge clk); #1;
    exp_q.push_back(mk(1, 8'h11, 1'b1, 1'b1));
    send(8'h11, 2'd1, 1'b1, 1'b1, 1);
    drain_and_finish("bypass");

    // Demosaic on the reference 4x2 frame.
    load_spec_frame(10);
    push_rgb(10, 21, 50, 1'b0, 1'b0);
    push_rgb(30, 40, 60, 1'b1, 1'b1);
    drive_frame(2'd1, 2);
    drain_and_finish("demosaic");

    // Mean of the same frame.
    load_spec_frame(10);
    push_rgb(20, 30, 55, 1'b1, 1'b1);
    drive_frame(2'd2, 2);
    drain_and_finish("mean");

`ifdef ISP_GAIN_EN
    // R=200 with a 2.0 gain saturates the RED beat.
    load_spec_frame(200);
    exp_q.push_back(mk(1, 255, 1'b0, 1'b0));
    exp_q.push_back(mk(2, gf(21, 16), 1'b0, 1'b0));
    exp_q.push_back(mk(3, gf(50, 24), 1'b0, 1'b0));
    push_rgb(30, 40, 60, 1'b1, 1'b1);
    drive_frame(2'd1, 2);
    drain_and_finish("gain_sat");
`endif

    // Early frame end on an even row: a single completion-only beat.
    mode_in = 2'd1;
    exp_q.push_back(mk(0, 0, 1'b0, 1'b1));
    send(8'd10, 2'd0, 1'b0, 1'b0, 1);
    send(8'd20, 2'd0, 1'b0, 1'b1, 1);
    drain_and_finish("early_end");

    // Reset in the middle of an odd row, then a fresh frame with unrelated data.
    mode_in = 2'd1;
    for (int c = 0; c < IC; c++) send(8'(200 + c), 2'd0, c == IC - 1, 1'b0, 1);
    send(8'd250, 2'd0, 1'b0, 1'b0, 1);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    check("midrst_finish", 32'(finish_operation), 32'd0);
    for (int r = 0; r < 2; r++) for (int c = 0; c < IC; c++) begin
      img[r][c] = 8'($urandom_range(0, 99));
      clr[r][c] = 2'd0;
    end
    model_frame(2'd1, 2);
    drive_frame(2'd1, 2);
    drain_and_finish("post_reset");

    // Randomised frames across all modes.
    for (int f = 0; f < 20; f++) begin
      logic [1:0] m;
      int rows;
      m    = 2'($urandom_range(0, 3));
      rows = (m == 2'd2) ? 2 : 2 * $urandom_range(1, 2);
      for (int r = 0; r < 4; r++) for (int c = 0; c < IC; c++) begin
        img[r][c] = 8'($urandom);
        clr[r][c] = 2'($urandom);
      end
      model_frame(m, rows);
      drive_frame(m, rows);
      drain_and_finish("random");
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
